// File: rtl/ex_pkg.sv
// Shared types and constants for the ID/EX issue stage: ALU funct codes,
// default widths, the held-entry record and the immediate extension helper.
package ex_pkg;

    localparam int EX_DATA_W   = 32;
    localparam int EX_REG_ID_W = 5;
    localparam int EX_IMM_W    = 16;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_EQ   = 6'b111111;

    typedef struct packed {
        logic [5:0]             funct;
        logic [EX_REG_ID_W-1:0] rs_id;
        logic [EX_REG_ID_W-1:0] rt_id;
        logic [EX_REG_ID_W-1:0] rd_id;
        logic [EX_DATA_W-1:0]   op1;
        logic [EX_DATA_W-1:0]   op2;
        logic                   use_rt;
        logic                   reg_write;
    } ex_entry_t;

    function automatic logic [EX_DATA_W-1:0] ext_imm(input logic [EX_IMM_W-1:0] imm,
                                                     input logic               sign_ext);
        logic [EX_DATA_W-EX_IMM_W-1:0] hi;
        if (sign_ext) begin
            hi = {(EX_DATA_W-EX_IMM_W){imm[EX_IMM_W-1]}};
        end else begin
            hi = {(EX_DATA_W-EX_IMM_W){1'b0}};
        end
        return {hi, imm};
    endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-to-ALU bus of the issue stage: input offer, flush, forwarding sources
// and the ALU-facing output handshake. master = pipeline driver, slave = stage.
interface ex_issue_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int IMM_W    = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [5:0]          in_funct;
    logic [REG_ID_W-1:0] in_rs_id;
    logic [REG_ID_W-1:0] in_rt_id;
    logic [REG_ID_W-1:0] in_rd_id;
    logic [DATA_W-1:0]   in_rs_val;
    logic [DATA_W-1:0]   in_rt_val;
    logic [IMM_W-1:0]    in_imm;
    logic                in_use_imm;
    logic                in_imm_signed;
    logic                in_reg_write;
    logic                flush;
    logic                exm_reg_write;
    logic [REG_ID_W-1:0] exm_rd_id;
    logic [DATA_W-1:0]   exm_result;
    logic                wb_reg_write;
    logic [REG_ID_W-1:0] wb_rd_id;
    logic [DATA_W-1:0]   wb_data;
    logic                out_valid;
    logic                out_ready;
    logic [5:0]          alu_selector;
    logic [DATA_W-1:0]   alu_input1;
    logic [DATA_W-1:0]   alu_input2;
    logic [REG_ID_W-1:0] out_rd_id;
    logic                out_reg_write;

    modport master (
        output in_valid, in_funct, in_rs_id, in_rt_id, in_rd_id, in_rs_val, in_rt_val,
               in_imm, in_use_imm, in_imm_signed, in_reg_write, flush,
               exm_reg_write, exm_rd_id, exm_result, wb_reg_write, wb_rd_id, wb_data,
               out_ready,
        input  in_ready, out_valid, alu_selector, alu_input1, alu_input2,
               out_rd_id, out_reg_write
    );

    modport slave (
        input  in_valid, in_funct, in_rs_id, in_rt_id, in_rd_id, in_rs_val, in_rt_val,
               in_imm, in_use_imm, in_imm_signed, in_reg_write, flush,
               exm_reg_write, exm_rd_id, exm_result, wb_reg_write, wb_rd_id, wb_data,
               out_ready,
        output in_ready, out_valid, alu_selector, alu_input1, alu_input2,
               out_rd_id, out_reg_write
    );
endinterface

// File: rtl/ex_issue_stage_fwd_mux.sv
// One operand's forwarding select: EX/MEM beats MEM/WB beats the held value;
// register 0 never matches.
module fwd_mux #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5
) (
    input  logic                en_i,
    input  logic [REG_ID_W-1:0] src_id_i,
    input  logic [DATA_W-1:0]   held_i,
    input  logic                exm_reg_write_i,
    input  logic [REG_ID_W-1:0] exm_rd_id_i,
    input  logic [DATA_W-1:0]   exm_result_i,
    input  logic                wb_reg_write_i,
    input  logic [REG_ID_W-1:0] wb_rd_id_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    output logic [DATA_W-1:0]   val_o
);
    logic src_nz_s;
    logic exm_hit_s;
    logic wb_hit_s;

    assign src_nz_s  = (src_id_i != {REG_ID_W{1'b0}});
    assign exm_hit_s = en_i && src_nz_s && exm_reg_write_i && (exm_rd_id_i == src_id_i);
    assign wb_hit_s  = en_i && src_nz_s && wb_reg_write_i && (wb_rd_id_i == src_id_i);

    // Priority select of the youngest producer.
    always_comb begin
        val_o = held_i;
        if (exm_hit_s) begin
            val_o = exm_result_i;
        end else if (wb_hit_s) begin
            val_o = wb_data_i;
        end else begin
            val_o = held_i;
        end
    end
endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register feeding the ALU. EX_FORWARD_EN selects operand forwarding;
// when undefined, dependent instructions are held at the input instead.
module ex_issue_stage
    import ex_pkg::*;
#(
    parameter int DATA_W   = EX_DATA_W,
    parameter int REG_ID_W = EX_REG_ID_W,
    parameter int IMM_W    = EX_IMM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_issue_stage_if.slave  bus
);
    ex_entry_t           entry_q, entry_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   op1_s, op2_s;
    logic [IMM_W-1:0]    imm_s;
    logic                hazard_s;
    logic                ready_s;
    logic                capture_s;

    assign imm_s = bus.in_imm;

`ifdef EX_FORWARD_EN
    fwd_mux #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W)) u_fwd_rs (
        .en_i(valid_q), .src_id_i(entry_q.rs_id), .held_i(entry_q.op1),
        .exm_reg_write_i(bus.exm_reg_write), .exm_rd_id_i(bus.exm_rd_id),
        .exm_result_i(bus.exm_result), .wb_reg_write_i(bus.wb_reg_write),
        .wb_rd_id_i(bus.wb_rd_id), .wb_data_i(bus.wb_data), .val_o(op1_s)
    );

    // Immediate operands must never be replaced by a forwarded register value.
    fwd_mux #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W)) u_fwd_rt (
        .en_i(valid_q && entry_q.use_rt), .src_id_i(entry_q.rt_id), .held_i(entry_q.op2),
        .exm_reg_write_i(bus.exm_reg_write), .exm_rd_id_i(bus.exm_rd_id),
        .exm_result_i(bus.exm_result), .wb_reg_write_i(bus.wb_reg_write),
        .wb_rd_id_i(bus.wb_rd_id), .wb_data_i(bus.wb_data), .val_o(op2_s)
    );

    assign hazard_s = 1'b0;
`else
    logic rs_busy_s, rt_busy_s;
    logic fwd_path_unused_s;

    function automatic logic id_busy(input logic [REG_ID_W-1:0] id,
                                     input logic held_w, input logic [REG_ID_W-1:0] held_rd,
                                     input logic exm_w,  input logic [REG_ID_W-1:0] exm_rd,
                                     input logic wb_w,   input logic [REG_ID_W-1:0] wb_rd);
        return (id != {REG_ID_W{1'b0}}) &&
               ((held_w && (held_rd == id)) || (exm_w && (exm_rd == id)) ||
                (wb_w && (wb_rd == id)));
    endfunction

    assign op1_s = entry_q.op1;
    assign op2_s = entry_q.op2;

    // An offered instruction waits while any in-flight producer owns a source it reads.
    assign rs_busy_s = id_busy(bus.in_rs_id, valid_q && entry_q.reg_write, entry_q.rd_id,
                               bus.exm_reg_write, bus.exm_rd_id, bus.wb_reg_write, bus.wb_rd_id);
    assign rt_busy_s = !bus.in_use_imm &&
                       id_busy(bus.in_rt_id, valid_q && entry_q.reg_write, entry_q.rd_id,
                               bus.exm_reg_write, bus.exm_rd_id, bus.wb_reg_write, bus.wb_rd_id);
    assign hazard_s  = rs_busy_s || rt_busy_s;

    assign fwd_path_unused_s = ^{bus.exm_result, bus.wb_data, entry_q.rs_id,
                                 entry_q.rt_id, entry_q.use_rt};
`endif

    assign ready_s   = (!valid_q || bus.out_ready) && !hazard_s;
    assign capture_s = bus.in_valid && ready_s && !bus.flush;

    // Next-state: flush beats capture; a stalled entry absorbs forwarded values.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            valid_d           = 1'b1;
            entry_d.funct     = bus.in_funct;
            entry_d.rs_id     = bus.in_rs_id;
            entry_d.rt_id     = bus.in_rt_id;
            entry_d.rd_id     = bus.in_rd_id;
            entry_d.op1       = bus.in_rs_val;
            entry_d.op2       = bus.in_use_imm ? ext_imm(imm_s, bus.in_imm_signed)
                                               : bus.in_rt_val;
            entry_d.use_rt    = !bus.in_use_imm;
            entry_d.reg_write = bus.in_reg_write;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            entry_d.op1 = op1_s;
            entry_d.op2 = op2_s;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready      = ready_s;
    assign bus.out_valid     = valid_q;
    assign bus.alu_selector  = entry_q.funct;
    assign bus.alu_input1    = op1_s;
    assign bus.alu_input2    = op2_s;
    assign bus.out_rd_id     = entry_q.rd_id;
    assign bus.out_reg_write = entry_q.reg_write;
endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed self-checking bench for ex_issue_stage; expectations follow
// EX_FORWARD_EN when that macro is defined for the build.
module tb_ex_issue_stage;
    import ex_pkg::*;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ex_issue_stage_if #(.DATA_W(32), .REG_ID_W(5), .IMM_W(16)) bus ();

    ex_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_funct      = 6'd0;
        bus.in_rs_id      = 5'd0;
        bus.in_rt_id      = 5'd0;
        bus.in_rd_id      = 5'd0;
        bus.in_rs_val     = 32'd0;
        bus.in_rt_val     = 32'd0;
        bus.in_imm        = 16'd0;
        bus.in_use_imm    = 1'b0;
        bus.in_imm_signed = 1'b0;
        bus.in_reg_write  = 1'b0;
    endtask

    task automatic offer(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic [15:0] imm, input logic use_imm, input logic sgn,
                         input logic rw);
        bus.in_valid      = 1'b1;
        bus.in_funct      = fn;
        bus.in_rs_id      = rs;
        bus.in_rt_id      = rt;
        bus.in_rd_id      = rd;
        bus.in_rs_val     = rsv;
        bus.in_rt_val     = rtv;
        bus.in_imm        = imm;
        bus.in_use_imm    = use_imm;
        bus.in_imm_signed = sgn;
        bus.in_reg_write  = rw;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b1;
        bus.exm_reg_write = 1'b0;
        bus.exm_rd_id     = 5'd0;
        bus.exm_result    = 32'd0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd_id      = 5'd0;
        bus.wb_data       = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_sel", {26'd0, bus.alu_selector}, 32'd0);
        check_eq("rst_in1", bus.alu_input1, 32'd0);
        check_eq("rst_in2", bus.alu_input2, 32'd0);
        check_eq("rst_rd", {27'd0, bus.out_rd_id}, 32'd0);
        check_eq("rst_rw", {31'd0, bus.out_reg_write}, 32'd0);
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill: ADD r3 = r1(5) + r2(7)
        @(negedge clk);
        offer(FN_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0, 1'b1);
        #1 check_eq("fill_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("fill_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("fill_sel", {26'd0, bus.alu_selector}, 32'h20);
        check_eq("fill_in1", bus.alu_input1, 32'd5);
        check_eq("fill_in2", bus.alu_input2, 32'd7);
        check_eq("fill_rd", {27'd0, bus.out_rd_id}, 32'd3);
        check_eq("fill_rw", {31'd0, bus.out_reg_write}, 32'd1);

        // Immediates, with an EX/MEM producer on the (unused) rt
        @(negedge clk);
        offer(FN_ADD, 5'd1, 5'd6, 5'd7, 32'd5, 32'd123, 16'hFFFC, 1'b1, 1'b1, 1'b1);
        bus.exm_reg_write = 1'b1;
        bus.exm_rd_id     = 5'd6;
        bus.exm_result    = 32'hDEAD_BEEF;
        #1 check_eq("imm_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("imm_sext_in2", bus.alu_input2, 32'hFFFF_FFFC);
        check_eq("imm_sext_in1", bus.alu_input1, 32'd5);
        @(negedge clk);
        bus.in_imm_signed = 1'b0;
        tick();
        check_eq("imm_zext_in2", bus.alu_input2, 32'h0000_FFFC);

        // Stall persistence
        @(negedge clk);
        bus.exm_reg_write = 1'b0;
        offer(FN_OR, 5'd4, 5'd2, 5'd8, 32'd11, 32'd22, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("or_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("or_sel", {26'd0, bus.alu_selector}, 32'h25);
        check_eq("or_in2", bus.alu_input2, 32'd22);
        @(negedge clk);
        idle();
        bus.out_ready    = 1'b0;
        bus.wb_reg_write = 1'b1;
        bus.wb_rd_id     = 5'd4;
        bus.wb_data      = 32'd99;
        #1;
        check_eq("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("stall_fwd_in1", bus.alu_input1, FWD ? 32'd99 : 32'd11);
        @(negedge clk);
        bus.wb_reg_write = 1'b0;
        #1;
        check_eq("stall_keep_in1", bus.alu_input1, FWD ? 32'd99 : 32'd11);
        check_eq("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1 check_eq("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Flush kills held entry and same-cycle capture
        @(negedge clk);
        offer(FN_AND, 5'd9, 5'd10, 5'd11, 32'd3, 32'd4, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("and_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("and_sel", {26'd0, bus.alu_selector}, 32'h24);
        @(negedge clk);
        offer(FN_SUB, 5'd12, 5'd0, 5'd13, 32'd100, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        bus.flush = 1'b1;
        #1 check_eq("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        idle();
        tick();
        check_eq("flush_nocap_valid", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            offer(FN_XOR, 5'(1 + i), 5'd0, 5'(20 + i), 32'(100 + i), 32'd0,
                  16'd0, 1'b0, 1'b0, 1'b1);
            tick();
            check_eq($sformatf("b2b_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check_eq($sformatf("b2b_in1_%0d", i), bus.alu_input1, 32'(100 + i));
        end
        @(negedge clk);
        idle();
        tick();
        check_eq("b2b_drain", {31'd0, bus.out_valid}, 32'd0);

        // Forward priority on a held rs=3 (value 1)
        @(negedge clk);
        offer(FN_ADD, 5'd3, 5'd0, 5'd9, 32'd1, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        bus.exm_reg_write = 1'b1;
        bus.exm_rd_id     = 5'd3;
        bus.exm_result    = 32'd10;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd_id      = 5'd3;
        bus.wb_data       = 32'd20;
        #1 check_eq("fwd_both_in1", bus.alu_input1, FWD ? 32'd10 : 32'd1);
        bus.exm_reg_write = 1'b0;
        #1 check_eq("fwd_wb_in1", bus.alu_input1, FWD ? 32'd20 : 32'd1);
        bus.wb_reg_write = 1'b0;

        // Register 0 is never forwarded nor a hazard
        @(negedge clk);
        offer(FN_ADD, 5'd0, 5'd0, 5'd9, 32'd1, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        bus.exm_reg_write = 1'b1;
        bus.exm_rd_id     = 5'd0;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd_id      = 5'd0;
        #1 check_eq("r0_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("r0_in1", bus.alu_input1, 32'd1);
        @(negedge clk);
        idle();
        bus.exm_reg_write = 1'b0;
        bus.wb_reg_write  = 1'b0;
        tick();

        // Dependent instruction behind producer rd=5
        @(negedge clk);
        offer(FN_ADD, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        offer(FN_SUB, 5'd5, 5'd0, 5'd14, 32'd42, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        #1 check_eq("dep_in_ready", {31'd0, bus.in_ready}, FWD ? 32'd1 : 32'd0);
`ifdef EX_FORWARD_EN
        tick();
        check_eq("dep_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("dep_in1", bus.alu_input1, 32'd42);
`else
        tick();
        check_eq("dep_producer_gone", {31'd0, bus.out_valid}, 32'd0);
        bus.exm_reg_write = 1'b1;
        bus.exm_rd_id     = 5'd5;
        #1 check_eq("dep_exm_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.exm_reg_write = 1'b0;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd_id      = 5'd5;
        #1 check_eq("dep_wb_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("dep_wb_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        bus.wb_reg_write = 1'b0;
        #1 check_eq("dep_clear_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        check_eq("dep_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("dep_in1", bus.alu_input1, 32'd42);
        check_eq("dep_sel", {26'd0, bus.alu_selector}, 32'h22);
`endif

        // Asynchronous reset while an entry is held
        @(negedge clk);
        idle();
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("arst_in1", bus.alu_input1, 32'd0);
        check_eq("arst_rd", {27'd0, bus.out_rd_id}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the execute ALU.
- Captures a decoded instruction and builds the two 32-bit ALU operands, with EX/MEM- and MEM/WB-stage operand forwarding and immediate extension.
- Presents the 6-bit ALU function selector plus operands over a valid/ready handshake.
- Supports pipeline flush for branches taken later in the pipe.

Parameters:
- DATA_W, 32, operand/result width
- REG_ID_W, 5, register-file index width
- IMM_W, 16, raw immediate width

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode stage offers an instruction
- in_ready  output  1  stage can accept this cycle
- in_funct  input  6  ALU selector (MIPS funct encoding: 100000 ADD … 111111 EQ)
- in_rs_id / in_rt_id / in_rd_id  input  REG_ID_W  source/dest register ids
- in_rs_val / in_rt_val  input  DATA_W  register-file read data
- in_imm  input  IMM_W  raw immediate
- in_use_imm  input  1  input2 comes from the immediate, not rt
- in_imm_signed  input  1  1 = sign-extend, 0 = zero-extend
- in_reg_write  input  1  instruction writes in_rd_id
- flush  input  1  kill held entry and any same-cycle capture
- exm_reg_write, exm_rd_id, exm_result  input  1/REG_ID_W/DATA_W  EX/MEM forwarding source
- wb_reg_write, wb_rd_id, wb_data  input  1/REG_ID_W/DATA_W  MEM/WB forwarding source
- out_valid  output  1  ALU operands valid
- out_ready  input  1  downstream accepts
- alu_selector  output  6  registered funct
- alu_input1 / alu_input2  output  DATA_W  forwarded operands
- out_rd_id, out_reg_write  output  REG_ID_W/1  carried to EX/MEM

Behaviour:
- Reset (rst_n low, async): valid_q=0; held funct, ids, operands, reg_write all 0. So out_valid=0, alu_selector=0, alu_input1/2=0, out_rd_id=0, out_reg_write=0.
- One-entry slot: in_ready = !valid_q || out_ready. This is a combinational pass-through and a full-throughput, 1-cycle latency.
- Capture: in_valid && in_ready && !flush loads all fields; valid_q=1 next edge.
- Advance without capture: valid_q=0.
- flush has priority over capture and hold; valid_q=0 next edge. Data registers are don't-care but must not glitch outputs when out_valid=0.
- Operand 2 prepared at capture: in_use_imm ? ext(in_imm) : in_rt_val.
  - ext = sign-extend if in_imm_signed, else zero-extend.
  - use_rt flag stored = !in_use_imm.
- Forwarding (combinational on held entry), per source operand:
  - EX/MEM hit if exm_reg_write && exm_rd_id == src_id && src_id != 0.
  - Else MEM/WB hit with the same rule.
  - Else the held value.
  - EX/MEM wins when both hit. Register 0 is never forwarded.
  - alu_input2 forwarding applies only when use_rt=1.
- Stalled hold: when valid_q && !out_ready, any forwarding hit is written back into the held operand register. A value forwarded while stalled persists after the producer retires.
- No arithmetic performed here. Widths are exact; no truncation.
- in_ready is not gated by hazards in forwarding mode. Load-use hazards are resolved by decode, not here.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: no forwarding muxes; operands are the held values unchanged. in_ready is additionally forced low while any used, non-zero source of the offered instruction matches one of:
  - (valid_q && out_reg_write) out_rd_id
  - (exm_reg_write) exm_rd_id
  - (wb_reg_write) wb_rd_id
- The offered instruction therefore waits until the producer retires.

Decomposition:
- Package ex_pkg holds:
  - funct localparams (FN_ADD=6'b100000, FN_SUB, FN_MULT, FN_DIV, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT, FN_EQ)
  - DATA_W/REG_ID_W defaults
  - a packed struct ex_entry_t (funct, ids, operands, use_rt, reg_write)
- One natural sub-module, fwd_mux: one operand's priority select. It is instantiated twice.

Test Plan:
- Reset/fill: rst_n low → out_valid=0, alu_input1=0. Release, then offer ADD rs=1 (val 5), rt=2 (val 7) → next cycle out_valid=1, selector=100000, input1=5, input2=7.
- Immediate: in_use_imm=1, imm=16'hFFFC:
  - signed=1 → input2=32'hFFFFFFFC.
  - signed=0 → 32'h0000FFFC.
  - In both cases an exm hit on rt is ignored.
- Forward priority: held rs=3 (val 1). Drive exm_rd_id=3/exm_result=10 and wb_rd_id=3/wb_data=20 → input1=10. Drop exm_reg_write → input1=20. Repeat with rs=0 → input1=1.
- Stall persistence: out_ready=0, wb hit rs=4 data 99 for one cycle, then wb_reg_write=0 → input1 stays 99. Raise out_ready → accepted, out_valid=0 next if no input.
- Flush: flush=1 with in_valid=1 and a held entry → next cycle out_valid=0. Nothing captured.
- Back-to-back throughput: 4 instructions with out_ready=1 → 4 consecutive out_valid cycles. With EX_FORWARD_EN off and a dependent rs matching a held rd=5 → in_ready=0 until the producer clears wb.
